// File: rtl/user_lut_cell_if.sv
// -----------------------------------------------------------------------------
// user_lut_cell_if -- pin bundle of the user LUT cell.
//
// io_in  [7:0] : bit 0 clock, bit 1 reset (async, active-high), bit 2 cfg_en,
//                bit 3 cfg_data (serial table bit, MSB first),
//                bits 4 +: LUT_K LUT data inputs (in0 = bit 4), upper bits unused.
// io_out [7:0] : bit 0 lut_out, bit 1 cfg_busy, bit 2 cfg_done, bit 3 zero,
//                bits 7:4 edge_cnt.
//
// Modports: master drives io_in and observes io_out; slave is the cell itself.
// -----------------------------------------------------------------------------
interface user_lut_cell_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/user_lut_cell.sv
// -----------------------------------------------------------------------------
// user_lut_cell -- reconfigurable LUT_K-input lookup table with serial loader.
//
// The data inputs are registered once (in_q) and the table lookup is registered
// again (lut_q), giving a two-clock input-to-output latency. A new truth table is
// shifted in MSB first while cfg_en is held; the table in use (active_q) is only
// replaced by a complete load in the COMMIT state, so evaluation never sees a
// partially loaded table.
//
// Ports:
//   bus : user_lut_cell_if.slave -- clock and reset arrive on io_in[0] and
//         io_in[1]; see the interface file for the remaining pin map.
//
// Parameters:
//   LUT_K      : number of LUT inputs, 1..4.
//   INIT_TABLE : truth table loaded by reset (8'hEC = (in0 & in2) | in1).
//
// Optional feature (macro LUT_EDGE_COUNT_EN): when defined, io_out[7:4] counts
// rising edges of lut_out modulo 16; when undefined, io_out[7:4] is tied to 0
// and no counter or history flop exists.
// -----------------------------------------------------------------------------
module user_lut_cell #(
  parameter int                         LUT_K      = 3,
  parameter logic [(2**LUT_K)-1:0]      INIT_TABLE = 8'hEC
) (
  user_lut_cell_if.slave bus
);

  localparam int TBL_W = 2 ** LUT_K;
  localparam int CNT_W = $clog2(TBL_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TBL_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  logic             clk;
  logic             rst;
  logic             cfg_en;
  logic             cfg_data;
  logic [LUT_K-1:0] data_in;

  assign clk      = bus.io_in[0];
  assign rst      = bus.io_in[1];
  assign cfg_en   = bus.io_in[2];
  assign cfg_data = bus.io_in[3];
  assign data_in  = bus.io_in[4 +: LUT_K];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TBL_W-1:0] shift_q, shift_d;
  logic [TBL_W-1:0] active_q, active_d;
  logic [LUT_K-1:0] in_q;
  logic             lut_q;
  logic             cfg_busy;
  logic             cfg_done;
  logic [3:0]       edge_cnt;

  // State register: FSM, loader and two-stage evaluation pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      active_q <= INIT_TABLE;
      in_q     <= '0;
      lut_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      active_q <= active_d;
      in_q     <= data_in;
      // Lookup always uses the committed table, never shift_q.
      lut_q    <= active_q[in_q];
    end
  end

  // Next-state logic for the serial table loader.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    active_d = active_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_en) begin
          // The bit sampled on the entry cycle is the table MSB.
          state_d = ST_LOAD;
          shift_d = {{(TBL_W-1){1'b0}}, cfg_data};
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_q == CNT_FULL) begin
          // All bits are in; commit regardless of cfg_en.
          state_d = ST_COMMIT;
        end else if (cfg_en) begin
          shift_d = {shift_q[TBL_W-2:0], cfg_data};
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          // Aborted load: drop the partial table.
          state_d = ST_IDLE;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_COMMIT: begin
        active_d = shift_q;
        cnt_d    = '0;
        if (cfg_en) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A further load needs cfg_en to drop first.
        if (!cfg_en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  // Output decode of the loader state.
  always_comb begin
    cfg_busy = 1'b0;
    cfg_done = 1'b0;
    case (state_q)
      ST_LOAD:   cfg_busy = 1'b1;
      ST_COMMIT: cfg_done = 1'b1;
      default: begin
        cfg_busy = 1'b0;
        cfg_done = 1'b0;
      end
    endcase
  end

`ifdef LUT_EDGE_COUNT_EN
  logic       hist_q;
  logic [3:0] edge_cnt_q;

  // Rising-edge counter on lut_out, wrapping modulo 16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q     <= 1'b0;
      edge_cnt_q <= 4'd0;
    end else begin
      hist_q <= lut_q;
      if (lut_q && !hist_q) begin
        edge_cnt_q <= edge_cnt_q + 4'd1;
      end else begin
        edge_cnt_q <= edge_cnt_q;
      end
    end
  end

  assign edge_cnt = edge_cnt_q;
`else
  assign edge_cnt = 4'd0;
`endif

  assign bus.io_out = {edge_cnt, 1'b0, cfg_done, cfg_busy, lut_q};

endmodule

// File: tb/tb_user_lut_cell.sv
// -----------------------------------------------------------------------------
// tb_user_lut_cell -- directed bench for user_lut_cell (LUT_K = 3, INIT 8'hEC).
// Inputs change 1 time unit after a rising edge and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_user_lut_cell;

  logic       clk;
  logic       rst;
  logic       cfg_en;
  logic       cfg_data;
  logic [2:0] din;     // {in2, in1, in0}
  int         checks;
  int         errors;
  int         busy_cnt;
  int         done_cnt;
  logic [7:0] pat;

  user_lut_cell_if bus ();

  assign bus.io_in = {1'b0, din, cfg_data, cfg_en, rst, clk};

  user_lut_cell dut (.bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Present din and wait out the two-clock latency.
  task automatic eval(input logic [2:0] v);
    din = v;
    tick();
    tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
    din      = 3'b000;
    #3;
    chk("reset_outputs", bus.io_out, 8'h00);
    tick();
    tick();
    rst = 1'b0;

    // Default table 8'hEC
    eval(3'b101);
    chk("ec_101", {7'd0, bus.io_out[0]}, 8'd1);
    din = 3'b100;
    tick();
    chk("latency_old_value", {7'd0, bus.io_out[0]}, 8'd1);
    tick();
    chk("ec_100", {7'd0, bus.io_out[0]}, 8'd0);
    eval(3'b010);
    chk("ec_010", {7'd0, bus.io_out[0]}, 8'd1);

    // Aborted load after 5 bits
    cfg_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cfg_data = 1'b0;
      tick();
    end
    chk("abort_busy_during", {7'd0, bus.io_out[1]}, 8'd1);
    cfg_en = 1'b0;
    tick();
    chk("abort_busy_low", {7'd0, bus.io_out[1]}, 8'd0);
    chk("abort_no_done", {7'd0, bus.io_out[2]}, 8'd0);
    tick();
    chk("abort_no_done_later", {7'd0, bus.io_out[2]}, 8'd0);
    eval(3'b101);
    chk("abort_keep_101", {7'd0, bus.io_out[0]}, 8'd1);
    eval(3'b100);
    chk("abort_keep_100", {7'd0, bus.io_out[0]}, 8'd0);

    // Full load of 8'h80
    pat      = 8'h80;
    busy_cnt = 0;
    cfg_en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cfg_data = pat[7-i];
      tick();
      busy_cnt += int'(bus.io_out[1]);
    end
    cfg_en = 1'b0;
    chk("load80_busy_cycles", 8'(busy_cnt), 8'd8);
    tick();
    chk("load80_done", bus.io_out[3:0], 8'h4);
    tick();
    chk("load80_done_once", bus.io_out[3:0], 8'h0);
    eval(3'b111);
    chk("t80_111", {7'd0, bus.io_out[0]}, 8'd1);
    eval(3'b011);
    chk("t80_011", {7'd0, bus.io_out[0]}, 8'd0);
    eval(3'b010);
    chk("t80_010", {7'd0, bus.io_out[0]}, 8'd0);

    // cfg_en held for 12 cycles while loading 8'h01
    pat      = 8'h01;
    busy_cnt = 0;
    done_cnt = 0;
    cfg_en   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cfg_data = (i < 8) ? pat[7-i] : 1'b1;
      tick();
      busy_cnt += int'(bus.io_out[1]);
      done_cnt += int'(bus.io_out[2]);
    end
    chk("hold_busy_cycles", 8'(busy_cnt), 8'd8);
    chk("hold_one_commit", 8'(done_cnt), 8'd1);
    tick();
    chk("hold_wait_no_reload", bus.io_out[2:0] & 8'h6, 8'h0);
    cfg_en = 1'b0;
    tick();
    chk("wait_to_idle", bus.io_out[2:0] & 8'h6, 8'h0);
    eval(3'b000);
    chk("t01_000", {7'd0, bus.io_out[0]}, 8'd1);
    eval(3'b101);
    chk("t01_101", {7'd0, bus.io_out[0]}, 8'd0);

    // Reset in the middle of a load restores the initial table
    eval(3'b000);
    chk("pre_reset_lut", {7'd0, bus.io_out[0]}, 8'd1);
    cfg_en   = 1'b1;
    cfg_data = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_reset_busy", {7'd0, bus.io_out[1]}, 8'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", bus.io_out, 8'h00);
    tick();
    rst    = 1'b0;
    cfg_en = 1'b0;
    chk("post_reset_idle", bus.io_out, 8'h00);
    eval(3'b101);
    chk("reset_table_101", {7'd0, bus.io_out[0]}, 8'd1);
    eval(3'b000);
    chk("reset_table_000", {7'd0, bus.io_out[0]}, 8'd0);

    // Rising-edge counter: 17 pulses on in1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din = 3'b000;
    tick();
    tick();
    for (int i = 0; i < 17; i++) begin
      din = 3'b010;
      tick();
      din = 3'b000;
      tick();
    end
    tick();
    tick();
    tick();
    tick();
`ifdef LUT_EDGE_COUNT_EN
    chk("edge_cnt_wrap", {4'd0, bus.io_out[7:4]}, 8'd1);
`else
    chk("edge_cnt_tied", {4'd0, bus.io_out[7:4]}, 8'd0);
`endif
    chk("bit3_zero", {7'd0, bus.io_out[3]}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
